truth_table_sequencer: RTL and testbench

//   Upstream stimulus/check stage for the small combinational gates (first/AND, NOT, ...).
//   On start, walks stim through every input combination 0..2**N_IN-1 and holds each one
//   for SETTLE cycles. It then samples the gate output dut_out and compares it to the

---
 rtl/truth_table_sequencer.sv | 137 +++++++++++++
 tb/tb_truth_table_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
// Sweeps a small combinational gate through every input combination, holds each
// vector long enough for the gate to settle, samples the gate output once and
// compares it with the expected truth table. Reports a saturating mismatch count,
// a per-vector fail map, and a pass flag with a one-cycle done pulse at the end.
module truth_table_sequencer #(
  parameter int                   N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0] TRUTH  = 4'b1000,
  parameter int                   SETTLE = 2,
  parameter int                   ERR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        stim,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [(1<<N_IN)-1:0]   fail_vec
);

  localparam int NUM_VEC = 1 << N_IN;
  localparam int CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = N_IN'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;

  logic settle_last;
  logic vec_last;
  logic mismatch;

  assign settle_last = (cnt == CNT_LAST);
  assign vec_last    = (stim == VEC_LAST);
  // Only meaningful in CHECK; the datapath ignores it elsewhere so glitches while
  // the gate settles are never recorded.
  assign mismatch    = (dut_out != TRUTH[stim]);

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update from the same pre-edge values; blocking here would race with the
  // datapath register block below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_SETTLE;
      S_SETTLE: if (settle_last) state_next = S_CHECK;
      S_CHECK:  state_next = vec_last ? S_FINISH : S_SETTLE;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state; busy drops as FINISH is
  // entered so it never overlaps the done pulse.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_SETTLE: busy = 1'b1;
      S_CHECK:  busy = 1'b1;
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // Stimulus, settle counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stim      <= '0;
      cnt       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
      pass      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          // Results of the last sweep stay visible until a new sweep starts.
          if (start) begin
            stim      <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
          end
        end
        S_SETTLE: begin
          cnt <= settle_last ? '0 : cnt + 1'b1;
        end
        S_CHECK: begin
          if (mismatch) begin
            fail_vec[stim] <= 1'b1;
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
          end
          if (vec_last) begin
            // Pass is resolved here, with the final vector's result folded in,
            // so it is already valid while done is high in FINISH.
            pass <= (err_count == '0) && !mismatch;
          end else begin
            stim <= stim + 1'b1;
            cnt  <= '0;
          end
        end
        S_FINISH: begin
          stim <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer
// Directed bench: a table of full sweeps on the default (AND) configuration, then
// hand-written sequences for held start, mid-sweep reset, the one-input NOT
// configuration and a one-bit saturating error counter.
module tb_truth_table_sequencer;

  localparam logic [1:0] M_AND   = 2'd0;
  localparam logic [1:0] M_OR    = 2'd1;
  localparam logic [1:0] M_STUCK = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Default instance: N_IN=2, TRUTH=AND, SETTLE=2, ERR_W=8.
  logic       start_def = 1'b0;
  logic       dut_out_def;
  logic [1:0] mode = M_AND;
  logic [1:0] stim_def;
  logic       busy_def, done_def, pass_def;
  logic [7:0] err_def;
  logic [3:0] fail_def;

  // Gate under test driven by the selected mode.
  always_comb begin
    dut_out_def = 1'b0;
    case (mode)
      M_AND:   dut_out_def = &stim_def;
      M_OR:    dut_out_def = |stim_def;
      M_STUCK: dut_out_def = 1'b1;
      default: dut_out_def = 1'b0;
    endcase
  end

  truth_table_sequencer u_def (
    .clk(clk), .rst(rst), .start(start_def), .dut_out(dut_out_def),
    .stim(stim_def), .busy(busy_def), .done(done_def), .pass(pass_def),
    .err_count(err_def), .fail_vec(fail_def)
  );

  // One-input NOT instance with an ideal inverter.
  logic       start_not = 1'b0;
  logic [0:0] stim_not;
  logic       busy_not, done_not, pass_not;
  logic [7:0] err_not;
  logic [1:0] fail_not;

  truth_table_sequencer #(.N_IN(1), .TRUTH(2'b01), .SETTLE(1), .ERR_W(8)) u_not (
    .clk(clk), .rst(rst), .start(start_not), .dut_out(~stim_not[0]),
    .stim(stim_not), .busy(busy_not), .done(done_not), .pass(pass_not),
    .err_count(err_not), .fail_vec(fail_not)
  );

  // One-bit error counter instance driven by a stuck-at-1 output.
  logic       start_sat = 1'b0;
  logic [1:0] stim_sat;
  logic       busy_sat, done_sat, pass_sat;
  logic [0:0] err_sat;
  logic [3:0] fail_sat;

  truth_table_sequencer #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(2), .ERR_W(1)) u_sat (
    .clk(clk), .rst(rst), .start(start_sat), .dut_out(1'b1),
    .stim(stim_sat), .busy(busy_sat), .done(done_sat), .pass(pass_sat),
    .err_count(err_sat), .fail_vec(fail_sat)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] exp_err;
    logic [3:0] exp_fail;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[4];

  // Full sweep on the default instance; called and returns on a falling edge.
  // Cycle n is the period after the n-th rising edge counted from the accepting one.
  task automatic run_sweep(input vec_t v);
    int done_at  = -1;
    int stim_bad = 0;
    int busy_bad = 0;
    mode      = v.mode;
    start_def = 1'b1;
    for (int n = 0; n < 40 && done_at < 0; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start_def = 1'b0;
        check({v.name, " cleared at start"}, 32'({err_def, fail_def, pass_def}), 32'd0);
      end
      if (done_def) begin
        done_at = n;
        check({v.name, " busy low in done"}, 32'(busy_def), 32'd0);
        check({v.name, " pass"}, 32'(pass_def), 32'(v.exp_pass));
      end else begin
        if (stim_def !== 2'(n / 3)) stim_bad++;
        if (busy_def !== 1'b1) busy_bad++;
      end
    end
    check({v.name, " done latency"}, 32'(done_at), 32'd12);
    check({v.name, " stim sequence bad cycles"}, 32'(stim_bad), 32'd0);
    check({v.name, " busy bad cycles"}, 32'(busy_bad), 32'd0);
    check({v.name, " err_count"}, 32'(err_def), 32'(v.exp_err));
    check({v.name, " fail_vec"}, 32'(fail_def), 32'(v.exp_fail));
    @(negedge clk);
    check({v.name, " done single pulse"}, 32'(done_def), 32'd0);
    check({v.name, " pass held"}, 32'(pass_def), 32'(v.exp_pass));
    check({v.name, " stim back to 0"}, 32'(stim_def), 32'd0);
  endtask

  initial begin
    int done_at1, done_at2, done_win, busy13, busy14, done_cnt;

    vecs[0] = '{"and_ideal", M_AND,   8'd0, 4'b0000, 1'b1};
    vecs[1] = '{"or_gate",   M_OR,    8'd2, 4'b0110, 1'b0};
    vecs[2] = '{"stuck_one", M_STUCK, 8'd3, 4'b0111, 1'b0};
    vecs[3] = '{"and_again", M_AND,   8'd0, 4'b0000, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    start_def = 1'b1;  // rst wins over start
    @(negedge clk);
    check("reset stim", 32'(stim_def), 32'd0);
    check("reset busy", 32'(busy_def), 32'd0);
    check("reset done", 32'(done_def), 32'd0);
    check("reset pass", 32'(pass_def), 32'd0);
    check("reset err_count", 32'(err_def), 32'd0);
    check("reset fail_vec", 32'(fail_def), 32'd0);
    start_def = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("idle after reset busy", 32'(busy_def), 32'd0);

    // Table of full sweeps.
    for (int i = 0; i < 4; i++) begin
      run_sweep(vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Start held high for 20 cycles: one done in the window, re-accept after IDLE.
    mode = M_AND;
    done_at1 = -1; done_at2 = -1; done_win = 0; busy13 = -1; busy14 = -1;
    start_def = 1'b1;
    for (int n = 0; n < 31; n++) begin
      @(negedge clk);
      if (n == 19) start_def = 1'b0;
      if (n == 13) busy13 = int'(busy_def);
      if (n == 14) busy14 = int'(busy_def);
      if (done_def) begin
        if (n < 20) done_win++;
        if (done_at1 < 0) done_at1 = n;
        else if (done_at2 < 0) done_at2 = n;
      end
    end
    check("held start first done", 32'(done_at1), 32'd12);
    check("held start dones in window", 32'(done_win), 32'd1);
    check("held start idle after finish", 32'(busy13), 32'd0);
    check("held start re-accepted", 32'(busy14), 32'd1);
    check("held start second done", 32'(done_at2), 32'd26);
    @(negedge clk);

    // Reset during SETTLE of vector 2, with vector 1 already failed (OR gate).
    mode = M_OR;
    start_def = 1'b1;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (n == 0) start_def = 1'b0;
    end
    check("pre-reset stim", 32'(stim_def), 32'd2);
    check("pre-reset err_count", 32'(err_def), 32'd1);
    check("pre-reset fail_vec", 32'(fail_def), 32'b0010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy_def), 32'd0);
    check("abort stim", 32'(stim_def), 32'd0);
    check("abort err_count", 32'(err_def), 32'd0);
    check("abort fail_vec", 32'(fail_def), 32'd0);
    done_cnt = int'(done_def);
    repeat (20) begin
      @(negedge clk);
      done_cnt += int'(done_def);
    end
    check("abort no done", 32'(done_cnt), 32'd0);
    check("abort stays idle", 32'(busy_def), 32'd0);

    // NOT gate, one input, SETTLE=1: stim 0,1 each held 2 cycles, done at cycle 4.
    begin
      int done_at  = -1;
      int stim_bad = 0;
      start_not = 1'b1;
      for (int n = 0; n < 20 && done_at < 0; n++) begin
        @(negedge clk);
        if (n == 0) start_not = 1'b0;
        if (done_not) done_at = n;
        else if (stim_not !== 1'(n / 2)) stim_bad++;
      end
      check("not done latency", 32'(done_at), 32'd4);
      check("not stim sequence bad cycles", 32'(stim_bad), 32'd0);
      check("not pass", 32'(pass_not), 32'd1);
      check("not err_count", 32'(err_not), 32'd0);
      check("not fail_vec", 32'(fail_not), 32'd0);
    end

    // One-bit error counter with three mismatches saturates at 1.
    begin
      int done_at = -1;
      start_sat = 1'b1;
      for (int n = 0; n < 40 && done_at < 0; n++) begin
        @(negedge clk);
        if (n == 0) start_sat = 1'b0;
        if (done_sat) done_at = n;
      end
      check("sat done latency", 32'(done_at), 32'd12);
      check("sat err_count", 32'(err_sat), 32'd1);
      check("sat fail_vec", 32'(fail_sat), 32'b0111);
      check("sat pass", 32'(pass_sat), 32'd0);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
